// File: rtl/input_vector_fetcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : input_vector_fetcher_if
//  Description : Bundle of the command, buffer-read, output-stream and status
//                signals of the input vector fetcher.
//                master = fetcher side, slave = surrounding system side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface input_vector_fetcher_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 13
);
    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;

    // Input vector buffer read port
    logic              mem_CEN;
    logic              mem_WEN;
    logic              mem_RETN;
    logic [ADDR_W-1:0] mem_A;
    logic [DATA_W-1:0] mem_Q;

    // Output vector stream
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    // Status
    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, mem_Q, out_ready,
        output cmd_ready, mem_CEN, mem_WEN, mem_RETN, mem_A,
               out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, mem_Q, out_ready,
        input  cmd_ready, mem_CEN, mem_WEN, mem_RETN, mem_A,
               out_valid, out_data, out_last, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/input_vector_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : input_vector_fetcher
//  Description : Reads a run of vectors from the input vector buffer (address
//                wrapping modulo DEPTH) and streams them out through a 4-entry
//                FIFO with valid/ready flow control and an out_last marker.
//                Buffer reads are throttled so that FIFO occupancy plus reads
//                still in flight never exceeds the FIFO depth.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_vector_fetcher #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 2048
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input_vector_fetcher_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_armed;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic              r_cen;
    logic [ADDR_W-1:0] r_mem_a;
    logic              r_cen_last;
    logic              r_qv;
    logic              r_q_last;
    logic [DATA_W:0]   r_fifo [4];
    logic [1:0]        r_wr_ptr;
    logic [1:0]        r_rd_ptr;
    logic [2:0]        r_count;
    logic              r_zero_done;

    logic              w_issue;
    logic              w_latch;
    logic              w_zero_cmd;
    logic [2:0]        w_inflight;
    logic              w_space;
    logic              w_cmd_hs;
    logic              w_out_hs;
    logic              w_last_hs;
    logic [DATA_W:0]   w_head;
    logic [ADDR_W-1:0] w_addr_inc;

    // A read occupies one cycle on the buffer port (r_cen low) and one more
    // cycle as returning data (r_qv); both must fit in the FIFO on arrival.
    assign w_inflight = {2'b00, ~r_cen} + {2'b00, r_qv};
    assign w_space    = (r_count + w_inflight) < 3'd4;
    assign w_cmd_hs   = bus.cmd_valid && bus.cmd_ready;
    assign w_out_hs   = bus.out_valid && bus.out_ready;
    assign w_head     = r_fifo[r_rd_ptr];
    assign w_last_hs  = w_out_hs && w_head[DATA_W];
    assign w_addr_inc = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and read-issue decision
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_latch     = 1'b0;
        w_zero_cmd  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_hs) begin
                    if (bus.cmd_len != '0) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_zero_cmd  = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if ((r_remaining != '0) && w_space) begin
                    w_issue = 1'b1;
                    if (r_remaining == ADDR_W'(1)) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_last_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command address/length tracking
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (w_latch) begin
            r_addr      <= bus.cmd_addr;
            r_remaining <= bus.cmd_len;
        end else if (w_issue) begin
            r_addr      <= w_addr_inc;
            r_remaining <= r_remaining - ADDR_W'(1);
        end
    end

    // Registered buffer read port; address holds between reads
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cen      <= 1'b1;
            r_mem_a    <= '0;
            r_cen_last <= 1'b0;
        end else begin
            r_cen      <= ~w_issue;
            r_cen_last <= w_issue && (r_remaining == ADDR_W'(1));
            if (w_issue) begin
                r_mem_a <= r_addr;
            end
        end
    end

    // Track which cycle carries returning read data and its last flag
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_qv     <= 1'b0;
            r_q_last <= 1'b0;
        end else begin
            r_qv     <= ~r_cen;
            r_q_last <= ~r_cen && r_cen_last;
        end
    end

    // FIFO storage: data with its last flag in the top bit
    always_ff @(posedge CLK) begin
        if (r_qv) begin
            r_fifo[r_wr_ptr] <= {r_q_last, bus.mem_Q};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (r_qv) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_out_hs) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({r_qv, w_out_hs})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // cmd_ready gating after reset release and zero-length completion pulse
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_armed     <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_armed     <= 1'b1;
            r_zero_done <= w_zero_cmd;
        end
    end

    assign bus.cmd_ready = r_armed && (r_state == ST_IDLE);
    assign bus.mem_CEN   = r_cen;
    assign bus.mem_A     = r_mem_a;
    assign bus.mem_WEN   = 1'b1;
    assign bus.mem_RETN  = 1'b1;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = bus.out_valid ? w_head[DATA_W-1:0] : '0;
    assign bus.out_last  = bus.out_valid && w_head[DATA_W];
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_zero_done || ((r_state == ST_DRAIN) && w_last_hs);

endmodule
`default_nettype wire
